// File: rtl/axi4lite_uart_gpio_slave_if.sv
// AXI4-Lite bus bundle shared by the UART/GPIO register block and its masters.
interface axi4lite_uart_gpio_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4lite_uart_gpio_slave.sv
// AXI4-Lite register block: LED register, synchronised switch inputs and a
// byte TX FIFO drained by a UART serializer over a valid/ready port.
// A push into a full FIFO answers SLVERR so the master retransmits.
module axi4lite_uart_gpio_slave #(
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int LOCAL_ADDR_BITS = 16,
  parameter int LED_WIDTH       = 16,
  parameter int SW_WIDTH        = 16,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                       S_AXI_ACLK,
  input  logic                       S_AXI_ARESET,
  axi4lite_uart_gpio_slave_if.slave  s_axi,
  output logic [LED_WIDTH-1:0]       LED,
  input  logic [SW_WIDTH-1:0]        SW,
  output logic [7:0]                 TX_DATA,
  output logic                       TX_VALID,
  input  logic                       TX_READY
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    SEL_LED    = 2'd0,
    SEL_TX     = 2'd1,
    SEL_STATUS = 2'd2,
    SEL_SW     = 2'd3
  } reg_sel_e;

  typedef struct packed {
    logic     hit;
    reg_sel_e sel;
  } dec_t;

  // Only 0x0/0x4/0x8/0xC inside the local window are registers.
  function automatic dec_t decode(input logic [LOCAL_ADDR_BITS-1:0] off);
    dec_t d;
    d.hit = (off[LOCAL_ADDR_BITS-1:4] == '0) && (off[1:0] == 2'b00);
    d.sel = reg_sel_e'(off[3:2]);
    return d;
  endfunction

  logic                       clk;
  logic                       rst;
  assign clk = S_AXI_ACLK;
  assign rst = S_AXI_ARESET;

  logic                       live;
  logic                       aw_held, w_held;
  logic [LOCAL_ADDR_BITS-1:0] aw_addr_q;
  logic [31:0]                wdata_q;
  logic [3:0]                 wstrb_q;
  logic                       bvalid_q;
  logic [1:0]                 bresp_q;
  logic                       rvalid_q;
  logic [1:0]                 rresp_q;
  logic [31:0]                rdata_q;
  logic [LED_WIDTH-1:0]       led_q;
  logic [SW_WIDTH-1:0]        sw_meta, sw_sync;

  logic [7:0]                 mem [FIFO_DEPTH];
  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic [CW-1:0]              count;
  logic                       full, empty, push, pop;
  logic [8:0]                 count_ext;
  logic [7:0]                 stat_count;

  dec_t                       wr_dec, rd_dec;
  logic                       commit;
  logic [1:0]                 wr_resp;
  logic [31:0]                led_wr;
  logic [31:0]                rd_data;
  logic [1:0]                 rd_resp;
  logic                       aw_fire, w_fire, ar_fire;

  // Handshake readiness; held low during reset and until the first live cycle.
  assign s_axi.awready = live && !aw_held && !bvalid_q;
  assign s_axi.wready  = live && !w_held && !bvalid_q;
  assign s_axi.arready = live && !rvalid_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;

  assign aw_fire = s_axi.awvalid && s_axi.awready;
  assign w_fire  = s_axi.wvalid && s_axi.wready;
  assign ar_fire = s_axi.arvalid && s_axi.arready;

  assign commit  = aw_held && w_held;
  assign wr_dec  = decode(aw_addr_q);
  assign rd_dec  = decode(s_axi.araddr[LOCAL_ADDR_BITS-1:0]);

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  // Full is judged before this cycle's pop, so a pop never rescues a push.
  assign push    = commit && wr_dec.hit && (wr_dec.sel == SEL_TX) && wstrb_q[0] && !full;
  assign pop     = !empty && TX_READY;

  assign count_ext  = 9'(count);
  assign stat_count = count_ext[8] ? 8'hFF : count_ext[7:0];

  assign LED      = led_q;
  assign TX_DATA  = mem[rd_ptr];
  assign TX_VALID = !empty;

  // Write response code and strobe-merged LED value for the pending commit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_resp = RESP_OKAY;
    led_wr  = 32'(led_q);
    for (int b = 0; b < 4; b++) begin
      if (wstrb_q[b]) led_wr[8*b +: 8] = wdata_q[8*b +: 8];
    end
    if (!wr_dec.hit) wr_resp = RESP_DECERR;
    else if (wr_dec.sel == SEL_TX && wstrb_q[0] && full) wr_resp = RESP_SLVERR;
  end

  // Read mux over current (pre-commit) state.
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_DECERR;
    if (rd_dec.hit) begin
      rd_resp = RESP_OKAY;
      case (rd_dec.sel)
        SEL_LED:    rd_data = 32'(led_q);
        SEL_TX:     rd_data = '0;
        SEL_STATUS: rd_data = {16'h0, stat_count, 6'h0, full, empty};
        SEL_SW:     rd_data = 32'(sw_sync);
        default:    rd_data = '0;
      endcase
    end
  end

  // Write channel: capture AW and W independently, commit once both are held.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      live      <= 1'b0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      led_q     <= '0;
    end else begin
      live <= 1'b1;
      if (aw_fire) begin
        aw_held   <= 1'b1;
        aw_addr_q <= s_axi.awaddr[LOCAL_ADDR_BITS-1:0];
      end
      if (w_fire) begin
        w_held  <= 1'b1;
        wdata_q <= s_axi.wdata;
        wstrb_q <= s_axi.wstrb;
      end
      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_resp;
        if (wr_dec.hit && wr_dec.sel == SEL_LED) led_q <= led_wr[LED_WIDTH-1:0];
      end else if (bvalid_q && s_axi.bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Read channel: one-cycle registered response held until RREADY.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else if (ar_fire) begin
      rvalid_q <= 1'b1;
      rresp_q  <= rd_resp;
      rdata_q  <= rd_data;
    end else if (rvalid_q && s_axi.rready) begin
      rvalid_q <= 1'b0;
    end
  end

  // Two-flop synchroniser for the asynchronous switch inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
    end
  end

  // FIFO storage written on accepted pushes.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; count/pointers define validity.
    if (push) mem[wr_ptr] <= wdata_q[7:0];
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Bits the block intentionally ignores (protection, interconnect-decoded address bits).
  logic unused_ok;
  assign unused_ok = ^{s_axi.awprot, s_axi.arprot,
                       s_axi.awaddr[AXI_ADDR_WIDTH-1:LOCAL_ADDR_BITS],
                       s_axi.araddr[AXI_ADDR_WIDTH-1:LOCAL_ADDR_BITS],
                       led_wr, AXI_DATA_WIDTH[0]};

endmodule
